// File: rtl/sdio_spi_target.sv
// Zorro II target for the SDIO register window ($F0-$F7): synchronized strobe decode,
// DTACK after WAIT_STATES waits, and a mode-0 byte-wide SPI engine for the SD card.
module sdio_spi_target #(
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        C7M,
    input  logic        RESET_n,
    input  logic [7:0]  A_HIGH,
    input  logic [7:1]  A_LOW,
    input  logic        RW_n,
    input  logic        AS_n,
    input  logic        UDS_n,
    input  logic        LDS_n,
    input  logic [7:0]  BASE_SDIO,
    input  logic        SDIO_CONFIGURED_n,
    input  logic [15:0] D_IN,
    output logic [15:0] D_OUT,
    output logic        D_OE,
    output logic        DTACK_n,
    output logic        SD_SCK,
    output logic        SD_MOSI,
    output logic        SD_CS_n,
    input  logic        SD_MISO,
    input  logic        SD_CD_n
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    logic [1:0]  as_sy, uds_sy, lds_sy, cd_sy;
    logic        as_s, uds_s, lds_s, cd_s;
    state_t      state;
    logic [2:0]  wcnt;
    logic        dtack_r, oe_r, clr_ovr;
    logic [15:0] d_out_r, rd_val;
    logic        cs_en, ovr;
    logic [3:0]  div;
    logic        busy, sck, mosi, miso_b;
    logic [7:0]  sh, rx_byte;
    logic [3:0]  hcnt;
    logic [2:0]  bcnt;
    logic        hit, enter_ack, spi_start;
    logic [1:0]  idx;
    logic        unused_bits;

    always_ff @(posedge C7M or negedge RESET_n) begin
        if (!RESET_n) begin
            as_sy  <= 2'b11;
            uds_sy <= 2'b11;
            lds_sy <= 2'b11;
            cd_sy  <= 2'b11;
        end else begin
            as_sy  <= {as_sy[0], AS_n};
            uds_sy <= {uds_sy[0], UDS_n};
            lds_sy <= {lds_sy[0], LDS_n};
            cd_sy  <= {cd_sy[0], SD_CD_n};
        end
    end

    assign as_s  = as_sy[1];
    assign uds_s = uds_sy[1];
    assign lds_s = lds_sy[1];
    assign cd_s  = cd_sy[1];
    assign idx   = A_LOW[2:1];

    assign hit = !SDIO_CONFIGURED_n && (A_HIGH == BASE_SDIO) && (A_LOW[7:3] == 5'b11110)
                 && !as_s && (!uds_s || !lds_s);

    // The register action happens exactly once, on the edge that enters ACK.
    assign enter_ack = ((state == S_IDLE) && hit && (WAIT_STATES == 0))
                     || ((state == S_WAIT) && !as_s && (wcnt == 3'd1));

    assign spi_start = enter_ack && !RW_n && (idx == 2'd0) && !lds_s && !busy;

    always_comb begin
        rd_val = 16'h0000;
        case (idx)
            2'd0:    rd_val = {8'h00, rx_byte};
            2'd1:    rd_val = {4'h0, div, 7'h00, cs_en};
            2'd2:    rd_val = {13'h0000, ovr, !cd_s, busy};
            default: rd_val = 16'h0000;
        endcase
    end

    always_ff @(posedge C7M or negedge RESET_n) begin
        if (!RESET_n) begin
            state   <= S_IDLE;
            wcnt    <= 3'd0;
            dtack_r <= 1'b1;
            oe_r    <= 1'b0;
            d_out_r <= 16'h0000;
            clr_ovr <= 1'b0;
            cs_en   <= 1'b0;
            div     <= 4'd15;
            ovr     <= 1'b0;
        end else if (enter_ack) begin
            state   <= S_ACK;
            dtack_r <= 1'b0;
            if (RW_n) begin
                oe_r    <= 1'b1;
                d_out_r <= rd_val;
                clr_ovr <= (idx == 2'd2);
            end else begin
                if (idx == 2'd0 && !lds_s && busy)
                    ovr <= 1'b1;
                if (idx == 2'd1) begin
                    if (!lds_s) cs_en <= D_IN[0];
                    if (!uds_s) div   <= D_IN[11:8];
                end
            end
        end else begin
            case (state)
                S_IDLE: if (hit) begin
                    state <= S_WAIT;
                    wcnt  <= 3'(WAIT_STATES);
                end
                S_WAIT: begin
                    if (as_s) state <= S_IDLE;
                    else      wcnt  <= wcnt - 3'd1;
                end
                S_ACK: if (as_s) begin
                    state   <= S_IDLE;
                    dtack_r <= 1'b1;
                    oe_r    <= 1'b0;
                    clr_ovr <= 1'b0;
                    if (clr_ovr) ovr <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // SCK toggles every DIV+1 cycles; DIV is re-read at each half-period boundary.
    always_ff @(posedge C7M or negedge RESET_n) begin
        if (!RESET_n) begin
            busy    <= 1'b0;
            sck     <= 1'b0;
            mosi    <= 1'b1;
            miso_b  <= 1'b0;
            sh      <= 8'h00;
            hcnt    <= 4'd0;
            bcnt    <= 3'd0;
            rx_byte <= 8'hFF;
        end else if (spi_start) begin
            busy <= 1'b1;
            sck  <= 1'b0;
            sh   <= D_IN[7:0];
            mosi <= D_IN[7];
            hcnt <= div;
            bcnt <= 3'd0;
        end else if (busy) begin
            if (hcnt != 4'd0) begin
                hcnt <= hcnt - 4'd1;
            end else begin
                hcnt <= div;
                if (!sck) begin
                    sck    <= 1'b1;
                    miso_b <= SD_MISO;
                end else begin
                    sck <= 1'b0;
                    if (bcnt == 3'd7) begin
                        busy    <= 1'b0;
                        mosi    <= 1'b1;
                        rx_byte <= {sh[6:0], miso_b};
                    end else begin
                        sh   <= {sh[6:0], miso_b};
                        mosi <= sh[6];
                        bcnt <= bcnt + 3'd1;
                    end
                end
            end
        end
    end

    assign unused_bits = ^D_IN[15:12];

    assign D_OUT   = d_out_r;
    assign DTACK_n = dtack_r | AS_n;
    assign D_OE    = oe_r & !AS_n;
    assign SD_SCK  = sck;
    assign SD_MOSI = mosi;
    assign SD_CS_n = !cs_en;
endmodule
